// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Receive side of a multiplexed 7-segment display. It watches the segment bus
// and the active-low digit select, waits for each dwell to settle, and decodes
// the segment pattern back to BCD. It gathers the digits into a frame and
// publishes the frame with a one-cycle valid pulse. o_stale flags a display
// that has stopped producing frames.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYC  = 4,
    parameter logic [3:0]  DIGITS_MASK = 4'b1111,
    parameter int unsigned TIMEOUT     = 27_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_seg,
    input  logic [3:0]  i_dig,
    output logic [15:0] o_bcd,
    output logic [3:0]  o_dp,
    output logic [3:0]  o_err,
    output logic        o_frame_valid,
    output logic        o_stale
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYC + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT);

    // Segment pattern {a,b,c,d,e,f,g} to {illegal, value}. Any code outside 0-9
    // decodes to F and sets the illegal flag.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        case (pat)
            7'b1111110: return 5'h00;
            7'b0110000: return 5'h01;
            7'b1101101: return 5'h02;
            7'b1111001: return 5'h03;
            7'b0110011: return 5'h04;
            7'b1011011: return 5'h05;
            7'b1011111: return 5'h06;
            7'b1110000: return 5'h07;
            7'b1111111: return 5'h08;
            7'b1111011: return 5'h09;
            default:    return 5'h1F;
        endcase
    endfunction

    // Sampled bus and dwell tracking
    logic [7:0]        seg_q;
    logic [3:0]        dig_q;
    logic [STAB_W-1:0] stab;
    logic              captured;

    // Frame under assembly
    logic [15:0] shadow_bcd;
    logic [3:0]  shadow_dp;
    logic [3:0]  shadow_err;
    logic [3:0]  seen;

    logic [TMO_W-1:0] tmo;

    // Next-state terms
    logic        in_match;
    logic        dwell_done;
    logic        sel_valid;
    logic [1:0]  sel_idx;
    logic        capture;
    logic [4:0]  dec;
    logic [15:0] shadow_bcd_next;
    logic [3:0]  shadow_dp_next;
    logic [3:0]  shadow_err_next;
    logic [3:0]  seen_next;
    logic        frame_done;
    logic [TMO_W-1:0] tmo_next;

    // Dwell completion, selected digit, decode and frame completion
    always_comb begin
        // NOTE: every signal gets a default before any branch so none of them can infer a latch.
        sel_valid       = 1'b0;
        sel_idx         = 2'd0;
        shadow_bcd_next = shadow_bcd;
        shadow_dp_next  = shadow_dp;
        shadow_err_next = shadow_err;
        seen_next       = seen;

        in_match   = ({i_seg, i_dig} == {seg_q, dig_q});
        dwell_done = (stab == STAB_MAX) && !captured;
        dec        = decode_seg(seg_q[7:1]);

        // Only a select with exactly one low bit names a single digit.
        case (dig_q)
            4'b1110: begin sel_valid = 1'b1; sel_idx = 2'd0; end
            4'b1101: begin sel_valid = 1'b1; sel_idx = 2'd1; end
            4'b1011: begin sel_valid = 1'b1; sel_idx = 2'd2; end
            4'b0111: begin sel_valid = 1'b1; sel_idx = 2'd3; end
            default: begin sel_valid = 1'b0; sel_idx = 2'd0; end
        endcase

        capture = dwell_done && sel_valid;

        if (capture) begin
            shadow_bcd_next[{sel_idx, 2'b00} +: 4] = dec[3:0];
            shadow_dp_next[sel_idx]                = seg_q[0];
            shadow_err_next[sel_idx]               = dec[4];
            seen_next                              = seen | (4'b0001 << sel_idx);
        end

        frame_done = capture && ((seen_next & DIGITS_MASK) == DIGITS_MASK);

        // A completed frame restarts the timeout; otherwise count up and hold at TIMEOUT.
        if (frame_done)
            tmo_next = '0;
        else if (tmo == TMO_MAX)
            tmo_next = tmo;
        else
            tmo_next = tmo + 1'b1;
    end

    // Sample the bus and track how long the current value has been stable
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            seg_q    <= 8'h00;
            dig_q    <= 4'hF;
            stab     <= '0;
            captured <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop sees pre-edge values.
            seg_q <= i_seg;
            dig_q <= i_dig;
            if (!in_match) begin
                stab     <= '0;
                captured <= 1'b0;
            end else begin
                if (stab != STAB_MAX)
                    stab <= stab + 1'b1;
                // A settled dwell is used once, even when its select is blank or ambiguous.
                if (dwell_done)
                    captured <= 1'b1;
            end
        end
    end

    // Assemble the shadow frame and publish it when the required digits are present
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the shadow registers are small flops, not a memory, so they are reset like any other state.
            shadow_bcd    <= '0;
            shadow_dp     <= '0;
            shadow_err    <= '0;
            seen          <= '0;
            o_bcd         <= '0;
            o_dp          <= '0;
            o_err         <= '0;
            o_frame_valid <= 1'b0;
        end else begin
            shadow_bcd    <= shadow_bcd_next;
            shadow_dp     <= shadow_dp_next;
            shadow_err    <= shadow_err_next;
            seen          <= frame_done ? 4'b0000 : seen_next;
            o_frame_valid <= frame_done;
            if (frame_done) begin
                o_bcd <= shadow_bcd_next;
                o_dp  <= shadow_dp_next;
                o_err <= shadow_err_next;
            end
        end
    end

    // Count cycles since the last frame; stale once the count reaches TIMEOUT
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo     <= '0;
            o_stale <= 1'b0;
        end else begin
            tmo     <= tmo_next;
            o_stale <= (tmo_next == TMO_MAX);
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the 7-segment display drivers.
- Samples the segment bus (i_seg) and the active-low digit-select bus (i_dig) that a driver produces, waits until each dwell is stable, and decodes each segment pattern back to a BCD digit.
- Assembles a multi-digit frame and publishes it with a one-cycle valid pulse.
- Used in self-test, loopback and bench checking of any display driver in the design.

Parameters:
- STABLE_CYC, 4: consecutive identical samples required before a dwell is captured (range 1..255).
- DIGITS_MASK, 4'b1111: digits that must all be captured to complete a frame. Bit k corresponds to digit k.
- TIMEOUT, 27_000_000: cycles without a completed frame before o_stale asserts (1 s at 27 MHz).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous, active-high reset
- i_seg  input  8  segment bus, active-high; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp. Synchronous to i_clk.
- i_dig  input  4  digit select, active-low one-hot; bit k low selects digit k. Synchronous to i_clk.
- o_bcd  output  16  decoded frame; o_bcd[4k+3:4k] holds digit k
- o_dp  output  4  decimal-point state per digit
- o_err  output  4  per-digit flag: captured pattern was not a legal 0-9 code
- o_frame_valid  output  1  one-cycle pulse; o_bcd, o_dp and o_err are updated on the same edge
- o_stale  output  1  high once TIMEOUT cycles elapse with no frame

Behaviour:
- Reset (synchronous, i_rst high at an edge):
  - All outputs go to 0.
  - Sample register {seg_q, dig_q} = {8'h00, 4'hF}.
  - Stability counter, captured flag, seen mask, shadow registers and timeout counter all clear.
  - Reset during a dwell aborts it; no capture occurs.
- Stability counter, evaluated at every edge:
  - If {i_seg, i_dig} equals {seg_q, dig_q}, stab increments, saturating at STABLE_CYC.
  - Otherwise stab clears to 0 and the captured flag clears.
  - {seg_q, dig_q} is loaded from the inputs on every edge.
  - Result: with a new value first present at edge 0, stab = k after edge k.
- Capture condition, acted on at the next edge:
  - stab == STABLE_CYC, captured flag clear, and dig_q has exactly one zero bit.
  - On capture, the captured flag is set, so at most one capture occurs per dwell.
  - dig_q = 4'hF (blank) or a value with more than one zero bit: no capture and the mask is unchanged. The dwell is still consumed and does not capture later.
- Decode of seg_q[7:1] (dp ignored):
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9.
  - Match: shadow digit k = value, err_k = 0.
  - No match: digit k = 4'hF, err_k = 1.
  - dp_k = seg_q[0].
- Frame assembly:
  - seen |= (1 << k).
  - If (seen_next & DIGITS_MASK) == DIGITS_MASK at the capture edge:
    - o_bcd, o_dp and o_err load the full shadow, including the digit just captured.
    - o_frame_valid is 1 for exactly that cycle.
    - seen clears to 0.
  - Captures of digits outside DIGITS_MASK update the shadow but never complete a frame.
  - Re-capture of an already-seen digit before the frame completes overwrites the shadow; the mask is unchanged.
  - Latency: for a dwell that completes a frame, o_frame_valid is high in the cycle after edge STABLE_CYC+1 (edge 5 for the default).
- Stale detection:
  - The timeout counter increments each cycle and saturates at TIMEOUT.
  - It clears on the edge that raises o_frame_valid.
  - o_stale = (counter == TIMEOUT), registered.
  - A frame and saturation on the same edge: the frame wins, so o_stale = 0.
- Counter widths:
  - stab is $clog2(STABLE_CYC+1) bits.
  - The timeout counter is $clog2(TIMEOUT+1) bits.
  - Neither counter wraps.

Test Plan:
1. Single-digit display, stable value: DIGITS_MASK=4'b0001, STABLE_CYC=4; after reset hold i_dig=1110 and i_seg=11110010 for 20 cycles -> one o_frame_valid pulse after edge 5, o_bcd[3:0]=3, o_err=0, o_dp=0, no further pulses.
2. Glitch rejection: STABLE_CYC=4; drive seg 01100000 for 2 cycles, then 11011010 held -> no capture of the 2-cycle "1"; a single frame carrying o_bcd[3:0]=2.
3. Multiplexed scan: DIGITS_MASK=4'b1111; drive dig 1110/1101/1011/0111 with patterns for 4/3/2/1, each held 8 cycles -> exactly one pulse after the fourth dwell, o_bcd=16'h1234.
4. Illegal pattern and dp: digit 2 driven with 10000001 -> o_bcd[11:8]=F, o_err[2]=1, o_dp[2]=1 on frame completion.
5. Illegal select: dig=1100 and dig=1111, each held 10 cycles with valid seg -> no capture, seen mask unchanged, no o_frame_valid.
6. Reset and stale: TIMEOUT=100 with no dwells -> o_stale rises at cycle 100 and clears on the next frame. Separately, assert i_rst when stab=3 -> no capture and all outputs 0.
